// File: rtl/enc_ctrl_pkg.sv
// Shared encoding for the Keccak round sequencer: FSM states, step bit positions, round count.
package enc_ctrl_pkg;

  localparam int NUM_STEPS      = 5;
  localparam int NUM_ROUNDS_DEF = 24;

  localparam int STEP_COLP  = 0;
  localparam int STEP_ROT   = 1;
  localparam int STEP_PERM  = 2;
  localparam int STEP_REVAL = 3;
  localparam int STEP_ADDRC = 4;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    S_COLP,
    S_ROT,
    S_PERM,
    S_REVAL,
    S_ADDRC,
    WRITE,
    DONE
  } state_t;

  typedef logic [NUM_STEPS-1:0] step_vec_t;

  function automatic step_vec_t step_bit(input int pos);
    return step_vec_t'(1) << pos;
  endfunction

endpackage

// File: rtl/keccak_round_ctrl_if.sv
// Job request and step/writer control bundle between the job source (master) and the sequencer (slave).
interface keccak_round_ctrl_if #(
  parameter int FILE_IDX_W = 10,
  parameter int ROUND_W    = 5
);

  logic                                start;
  logic [FILE_IDX_W-1:0]               num_files;
  logic                                load_en;
  logic [enc_ctrl_pkg::NUM_STEPS-1:0]  step_en;
  logic [ROUND_W-1:0]                  round_idx;
  logic [FILE_IDX_W-1:0]               file_index;
  logic                                out_write;
  logic [enc_ctrl_pkg::NUM_STEPS-1:0]  dump_wr;
  logic                                busy;
  logic                                done;

  modport master (
    output start, num_files,
    input  load_en, step_en, round_idx, file_index, out_write, dump_wr, busy, done
  );

  modport slave (
    input  start, num_files,
    output load_en, step_en, round_idx, file_index, out_write, dump_wr, busy, done
  );

endinterface

// File: rtl/enc_round_counter.sv
// Round counter with clear, saturating increment and a last-round flag.
// Count updates on the edge after clr/inc; last is decoded from the count.
module enc_round_counter #(
  parameter int NUM_ROUNDS = 24,
  parameter int ROUND_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [ROUND_W-1:0] cnt,
  output logic               last
);

  assign last = (cnt == ROUND_W'(NUM_ROUNDS - 1));

  // Saturate at the last round so the RC select can never run off the table.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !last) begin
      cnt <= cnt + ROUND_W'(1);
    end
  end

endmodule

// File: rtl/keccak_round_ctrl.sv
// Keccak round sequencer: per file LOAD, NUM_ROUNDS x five one-cycle steps, WRITE; done after last file.
// 2 + 5*NUM_ROUNDS cycles per file, all strobes registered; optional step dumps under ENC_STEP_DUMP_EN.
module keccak_round_ctrl
  import enc_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
  parameter int FILE_IDX_W = 10,
  parameter int ROUND_W    = 5
) (
  input  logic                clk,
  input  logic                rst,
  keccak_round_ctrl_if.slave  bus
);

  state_t                state;
  logic [FILE_IDX_W-1:0] num_files_q;
  logic [FILE_IDX_W-1:0] file_index;
  logic                  load_en;
  logic                  out_write;
  logic                  busy;
  logic                  done;
  step_vec_t             step_en;
  step_vec_t             dump_wr;

  logic [ROUND_W-1:0]    round_idx;
  logic                  round_last;
  logic                  round_clr;
  logic                  round_inc;
  logic                  file_last;

  assign file_last = (file_index == num_files_q - FILE_IDX_W'(1));

  // The round counter restarts on every edge that enters LOAD.
  assign round_clr = ((state == IDLE) && bus.start) || ((state == WRITE) && !file_last);
  assign round_inc = (state == S_ADDRC) && !round_last;

  enc_round_counter #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .ROUND_W    (ROUND_W)
  ) u_round (
    .clk  (clk),
    .rst  (rst),
    .clr  (round_clr),
    .inc  (round_inc),
    .cnt  (round_idx),
    .last (round_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      num_files_q <= '0;
      file_index  <= '0;
      load_en     <= 1'b0;
      step_en     <= '0;
      out_write   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      load_en   <= 1'b0;
      step_en   <= '0;
      out_write <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            num_files_q <= bus.num_files;
            file_index  <= '0;
            if (bus.num_files != '0) begin
              state   <= LOAD;
              load_en <= 1'b1;
              busy    <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        LOAD: begin
          state   <= S_COLP;
          step_en <= step_bit(STEP_COLP);
        end
        S_COLP: begin
          state   <= S_ROT;
          step_en <= step_bit(STEP_ROT);
        end
        S_ROT: begin
          state   <= S_PERM;
          step_en <= step_bit(STEP_PERM);
        end
        S_PERM: begin
          state   <= S_REVAL;
          step_en <= step_bit(STEP_REVAL);
        end
        S_REVAL: begin
          state   <= S_ADDRC;
          step_en <= step_bit(STEP_ADDRC);
        end
        S_ADDRC: begin
          if (round_last) begin
            state     <= WRITE;
            out_write <= 1'b1;
          end else begin
            state   <= S_COLP;
            step_en <= step_bit(STEP_COLP);
          end
        end
        WRITE: begin
          if (file_last) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state      <= LOAD;
            load_en    <= 1'b1;
            file_index <= file_index + FILE_IDX_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ENC_STEP_DUMP_EN
  // Dump one cycle after the step so each writer sees the state that step produced.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dump_wr <= '0;
    end else begin
      dump_wr <= step_en & {NUM_STEPS{round_idx == '0}};
    end
  end
`else
  assign dump_wr = '0;
`endif

  assign bus.load_en    = load_en;
  assign bus.step_en    = step_en;
  assign bus.round_idx  = round_idx;
  assign bus.file_index = file_index;
  assign bus.out_write  = out_write;
  assign bus.dump_wr    = dump_wr;
  assign bus.busy       = busy;
  assign bus.done       = done;

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Bench for keccak_round_ctrl: cycle-indexed reference schedule compared on every negedge.
module tb_keccak_round_ctrl;

  localparam int NR       = 24;
  localparam int FW       = 10;
  localparam int RW       = 5;
  localparam int FILE_CYC = 2 + 5 * NR;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  keccak_round_ctrl_if #(.FILE_IDX_W(FW), .ROUND_W(RW)) bus();

  keccak_round_ctrl #(.NUM_ROUNDS(NR), .FILE_IDX_W(FW), .ROUND_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       load;
    bit [4:0] step;
    int       round;
    bit       wr;
    int       fidx;
    bit       busy;
    bit       done;
  } exp_t;

  // Expected outputs in cycle c of a job of n files, start sampled at edge 0.
  function automatic exp_t model(input int n, input int c);
    exp_t e;
    int d, t, r;
    e = '{default: 0};
    if (c < 1) return e;
    d = 1 + FILE_CYC * n;
    if (c < d) begin
      t      = c - 1;
      r      = t % FILE_CYC;
      e.busy = 1'b1;
      e.fidx = t / FILE_CYC;
      e.load = (r == 0);
      e.wr   = (r == FILE_CYC - 1);
      if (r >= 1 && r <= 5 * NR) begin
        e.step  = 5'(1 << ((r - 1) % 5));
        e.round = (r - 1) / 5;
      end else begin
        e.round = (r == 0) ? 0 : NR - 1;
      end
    end else begin
      e.done  = (c == d);
      e.fidx  = n - 1;
      e.round = NR - 1;
    end
    return e;
  endfunction

  task automatic test_reset();
    logic [28:0] obs;
    bus.start     = 1'b0;
    bus.num_files = '0;
    rst           = 1'b0;
    repeat (3) @(negedge clk);
    obs = {bus.load_en, bus.step_en, bus.round_idx, bus.file_index, bus.out_write,
           bus.dump_wr, bus.busy, bus.done};
    n_total++;
    if (obs !== 29'd0) $display("FAIL reset_outputs: got %h want 0", obs);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_files = FW'(2);
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (50) @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL busy_before_abort: got %b want 1", bus.busy);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    obs = {bus.load_en, bus.step_en, bus.round_idx, bus.file_index, bus.out_write,
           bus.dump_wr, bus.busy, bus.done};
    n_total++;
    if (obs !== 29'd0) $display("FAIL async_abort_outputs: got %h want 0", obs);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if ({bus.done, bus.busy} !== 2'b00)
        $display("FAIL abort_no_done: cycle %0d got done/busy %b want 00", i, {bus.done, bus.busy});
      else n_pass++;
    end
    rst = 1'b1;
  endtask

  // One job of n files, every output compared each cycle; perturb re-pulses start and scrambles num_files.
  task automatic test_job(input int n, input bit perturb, input string tag);
    exp_t     e, ep;
    int       d;
    bit [4:0] dexp;
    d = 1 + FILE_CYC * n;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_files = FW'(n);
    @(posedge clk);
    for (int c = 1; c <= d + 2; c++) begin
      @(negedge clk);
      e  = model(n, c);
      ep = model(n, c - 1);
`ifdef ENC_STEP_DUMP_EN
      dexp = (ep.round == 0) ? ep.step : 5'd0;
`else
      dexp = 5'd0;
`endif
      n_total++;
      if (bus.load_en !== e.load)
        $display("FAIL %s load_en c=%0d: got %b want %b", tag, c, bus.load_en, e.load);
      else n_pass++;
      n_total++;
      if (bus.step_en !== e.step)
        $display("FAIL %s step_en c=%0d: got %b want %b", tag, c, bus.step_en, e.step);
      else n_pass++;
      n_total++;
      if (bus.out_write !== e.wr)
        $display("FAIL %s out_write c=%0d: got %b want %b", tag, c, bus.out_write, e.wr);
      else n_pass++;
      n_total++;
      if (bus.busy !== e.busy)
        $display("FAIL %s busy c=%0d: got %b want %b", tag, c, bus.busy, e.busy);
      else n_pass++;
      n_total++;
      if (bus.done !== e.done)
        $display("FAIL %s done c=%0d: got %b want %b", tag, c, bus.done, e.done);
      else n_pass++;
      n_total++;
      if (bus.dump_wr !== dexp)
        $display("FAIL %s dump_wr c=%0d: got %b want %b", tag, c, bus.dump_wr, dexp);
      else n_pass++;
      if (n > 0) begin
        n_total++;
        if (bus.round_idx !== RW'(e.round))
          $display("FAIL %s round_idx c=%0d: got %0d want %0d", tag, c, bus.round_idx, e.round);
        else n_pass++;
        n_total++;
        if (bus.file_index !== FW'(e.fidx))
          $display("FAIL %s file_index c=%0d: got %0d want %0d", tag, c, bus.file_index, e.fidx);
        else n_pass++;
      end
      n_total++;
      if (!$onehot0(bus.step_en) || ((|bus.step_en) && (bus.load_en || bus.out_write)))
        $display("FAIL %s strobe_exclusive c=%0d: got step %b load %b write %b want one-hot0 step, no overlap",
                 tag, c, bus.step_en, bus.load_en, bus.out_write);
      else n_pass++;
      if (perturb && c < d) begin
        bus.start     = ($urandom_range(0, 3) == 0);
        bus.num_files = FW'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.num_files = FW'(n);
  endtask

  task automatic test_single_file();
    test_job(1, 1'b0, "one_file");
  endtask

  task automatic test_multi_file();
    test_job(3, 1'b0, "three_files");
  endtask

  task automatic test_zero_files();
    test_job(0, 1'b0, "zero_files");
  endtask

  task automatic test_midjob_noise();
    test_job(3, 1'b1, "midjob_noise");
  endtask

  task automatic test_dump_two_files();
    test_job(2, 1'b0, "dump_two_files");
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 3; j++) test_job(int'($urandom_range(1, 4)), 1'b1, "random_job");
  endtask

  initial begin
    test_reset();
    test_dump_two_files();
    test_single_file();
    test_multi_file();
    test_zero_files();
    test_midjob_noise();
    test_random_jobs();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
